fx_mul_sat_pipe: RTL

Parametrised signed fixed-point multiplier (Q(WIDTH-QFRAC).QFRAC) with a LATENCY-deep pipeline and valid/ready handshakes on both sides.
- Selectable truncate or round-half-up on the dropped fraction bits; saturating or wrapping overflow handling.
- Per-result overflow flag, sideband tag passthrough, and a sticky saturating overflow counter.
- Drop-in arithmetic primitive for the LSM regression and QMC path-generation datapaths, where downstream stages may stall.

---
 rtl/fx_pkg.sv | 27 ++
 rtl/fx_round_sat.sv | 38 +++
 rtl/fx_mul_sat_pipe.sv | 129 ++++++++++++
 3 files changed

// File: rtl/fx_pkg.sv
// Shared fixed-point helpers for the fx arithmetic primitives (multiplier now, adder/divider later).
package fx_pkg;

  localparam int FX_TRUNC       = 0;
  localparam int FX_RND_HALF_UP = 1;

  // Wide scratch type; every intermediate of a WIDTH<=63 primitive fits with sign headroom.
  localparam int FX_MAXW = 128;
  typedef logic signed [FX_MAXW-1:0] fx_wide_t;

  function automatic fx_wide_t fx_sat_max(input int width);
    fx_wide_t one;
    one = fx_wide_t'(1);
    return (one <<< (width - 1)) - one;
  endfunction

  function automatic fx_wide_t fx_sat_min(input int width);
    return ~fx_sat_max(width);
  endfunction

  function automatic logic fx_fits(input fx_wide_t x, input int width);
    fx_wide_t t;
    t = x >>> (width - 1);
    return (t == '0) || (t == '1);
  endfunction

endpackage

// File: rtl/fx_round_sat.sv
// Combinational round / shift / saturate from a 2*WIDTH signed product down to WIDTH bits.
module fx_round_sat
  import fx_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int QFRAC      = 16,
  parameter int ROUND_MODE = FX_RND_HALF_UP,
  parameter int SATURATE   = 1
) (
  input  logic [2*WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0]   res_o,
  output logic               ovf_o
);

  localparam int EW  = 2*WIDTH + 1;
  localparam int RSH = (QFRAC > 0) ? QFRAC - 1 : 0;
  localparam logic [EW-1:0] RND =
    (ROUND_MODE == FX_RND_HALF_UP && QFRAC > 0) ? (EW'(1) << RSH) : '0;
  localparam fx_wide_t SMAX = fx_sat_max(WIDTH);
  localparam fx_wide_t SMIN = fx_sat_min(WIDTH);

  logic signed [EW-1:0] ext;
  logic signed [EW-1:0] q;
  fx_wide_t             qx;

  // One guard bit keeps the rounding add from wrapping on the most positive product.
  assign ext   = $signed({raw_i[2*WIDTH-1], raw_i}) + $signed(RND);
  assign q     = ext >>> QFRAC;
  assign qx    = fx_wide_t'(q);
  assign ovf_o = !fx_fits(qx, WIDTH);

  always_comb begin
    res_o = q[WIDTH-1:0];
    if (SATURATE != 0 && ovf_o)
      res_o = q[EW-1] ? SMIN[WIDTH-1:0] : SMAX[WIDTH-1:0];
  end

endmodule

// File: rtl/fx_mul_sat_pipe.sv
// Pipelined signed Q-format multiplier with a single global stall, tag sideband and overflow counter.
module fx_mul_sat_pipe
  import fx_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int QFRAC      = 16,
  parameter int LATENCY    = 2,
  parameter int ROUND_MODE = FX_RND_HALF_UP,
  parameter int SATURATE   = 1,
  parameter int TAG_W      = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [TAG_W-1:0] out_tag,
  output logic             ovf,
  output logic [CNT_W-1:0] ovf_count,
  input  logic             ovf_clr
);

  localparam int PW = 2*WIDTH;

  logic                 en;
  logic signed [PW-1:0] a_x, b_x, prod;
  logic                 fin_vld;
  logic [TAG_W-1:0]     fin_tag;
  logic [PW-1:0]        fin_raw;
  logic [WIDTH-1:0]     rs_res;
  logic                 rs_ovf;

  logic                 vld_q;
  logic [WIDTH-1:0]     res_q;
  logic [TAG_W-1:0]     tag_q;
  logic                 ovf_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  assign en       = !vld_q || out_ready;
  assign in_ready = en;

  assign a_x  = {{WIDTH{a[WIDTH-1]}}, a};
  assign b_x  = {{WIDTH{b[WIDTH-1]}}, b};
  assign prod = a_x * b_x;

  // Raw product stages feed the final round/saturate stage; with LATENCY=1 it sees the inputs directly.
  if (LATENCY == 1) begin : g_l1
    assign fin_vld = in_valid;
    assign fin_tag = in_tag;
    assign fin_raw = prod;
  end else begin : g_ln
    logic [LATENCY-2:0]            vld_pipe;
    logic [LATENCY-2:0][TAG_W-1:0] tag_pipe;
    logic [LATENCY-2:0][PW-1:0]    raw_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_pipe <= '0;
        tag_pipe <= '0;
        raw_pipe <= '0;
      end else if (en) begin
        vld_pipe[0] <= in_valid;
        tag_pipe[0] <= in_tag;
        raw_pipe[0] <= prod;
        for (int i = 1; i < LATENCY - 1; i++) begin
          vld_pipe[i] <= vld_pipe[i-1];
          tag_pipe[i] <= tag_pipe[i-1];
          raw_pipe[i] <= raw_pipe[i-1];
        end
      end
    end

    assign fin_vld = vld_pipe[LATENCY-2];
    assign fin_tag = tag_pipe[LATENCY-2];
    assign fin_raw = raw_pipe[LATENCY-2];
  end

  fx_round_sat #(
    .WIDTH     (WIDTH),
    .QFRAC     (QFRAC),
    .ROUND_MODE(ROUND_MODE),
    .SATURATE  (SATURATE)
  ) u_round_sat (
    .raw_i(fin_raw),
    .res_o(rs_res),
    .ovf_o(rs_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      res_q <= '0;
      tag_q <= '0;
      ovf_q <= 1'b0;
    end else if (en) begin
      vld_q <= fin_vld;
      res_q <= rs_res;
      tag_q <= fin_tag;
      ovf_q <= rs_ovf;
    end
  end

  // Clear beats a same-cycle increment; the count sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (ovf_clr)
      cnt_d = '0;
    else if (vld_q && out_ready && ovf_q && cnt_q != '1)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign out_valid = vld_q;
  assign result    = res_q;
  assign out_tag   = tag_q;
  assign ovf       = ovf_q;
  assign ovf_count = cnt_q;

endmodule
